// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
//
// Passive receiver for an 8N1 UART line. Received bytes go into a small FIFO for a
// downstream consumer. Framing errors, dropped bytes and receiver activity are reported.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per UART bit (4..65535)
//   FIFO_DEPTH   : received-byte buffer entries (power of two, 2..64)
//
// Ports
//   clock      : clock; all logic on the rising edge
//   reset      : synchronous, active-low reset
//   rxd        : asynchronous serial input, idle high
//   out_valid  : FIFO non-empty; out_data holds the oldest byte
//   out_data   : oldest received byte (forced to 0 while the FIFO is empty)
//   out_ready  : consumer pops the FIFO when out_valid && out_ready
//   frame_err  : one-cycle pulse when a stop bit samples low
//   overflow   : sticky; a byte was dropped because the FIFO was full
//   drop_count : number of dropped bytes, saturating at 255
//   busy       : receiver state machine is not idle

module uart_rx_monitor #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rxd,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       frame_err,
   output logic       overflow,
   output logic [7:0] drop_count,
   output logic       busy
);

   localparam int unsigned TimerW = $clog2(CLKS_PER_BIT);
   localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
   localparam int unsigned PtrW   = AddrW + 1;

   // The timer counts down to zero.
   // Loading N-1 makes the expiry test fall on the Nth cycle.
   localparam logic [TimerW-1:0] BitLoad  = TimerW'(CLKS_PER_BIT - 1);
   localparam logic [TimerW-1:0] HalfLoad = TimerW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StBreak
   } state_e;

   // ------------------------------------------------------------------
   // Input synchronizer
   // ------------------------------------------------------------------
   logic [1:0] sync_q;
   logic       rxs;

   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rxd};
      end
   end

   assign rxs = sync_q[1];

   // ------------------------------------------------------------------
   // Receive state machine
   // ------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              frame_err_q, frame_err_d;
   logic              push;
   logic              timer_done;

   assign timer_done = (timer_q == '0);

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= StIdle;
         timer_q     <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      push        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rxs) begin
               state_d = StStart;
               timer_d = HalfLoad;
            end
         end

         // Re-check the line at mid start bit.
         // A line that is already high again was a glitch and is ignored silently.
         StStart: begin
            if (timer_done) begin
               if (!rxs) begin
                  state_d   = StData;
                  timer_d   = BitLoad;
                  bit_idx_d = 3'd0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end

         // LSB arrives first.
         // Shift right so that the first bit ends up in bit 0 after eight samples.
         StData: begin
            if (timer_done) begin
               shift_d   = {rxs, shift_q[7:1]};
               timer_d   = BitLoad;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end

         StStop: begin
            if (timer_done) begin
               if (rxs) begin
                  push    = 1'b1;
                  state_d = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StBreak;
               end
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end

         // Wait out a held-low line.
         // Restarting from idle here would report one framing error per frame time.
         StBreak: begin
            if (rxs) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign frame_err = frame_err_q;
   assign busy      = (state_q != StIdle);

   // ------------------------------------------------------------------
   // Receive FIFO
   // ------------------------------------------------------------------
   logic [7:0]      mem [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic            full, empty;
   logic            pop, wr_en, drop;
   logic            overflow_q;
   logic [7:0]      drop_count_q;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                  (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

   assign pop   = out_ready && !empty;
   // When the FIFO is full, a pop in the same cycle frees the slot the push needs.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_ptr_q[AddrW-1:0]] <= shift_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         if (drop) begin
            overflow_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
               drop_count_q <= drop_count_q + 8'd1;
            end
         end
      end
   end

   assign out_valid  = !empty;
   assign out_data   = empty ? 8'h00 : mem[rd_ptr_q[AddrW-1:0]];
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Testbench for uart_rx_monitor.
//
// Directed frames are driven onto rxd. A transaction-level model predicts the DUT
// response: the byte queue, the drop flags and the timing of frame_err.
// A compare process checks the DUT against the model on every cycle.
// Hand-computed literal checks pin the model's conclusions.

module tb_uart_rx_monitor;

   localparam int unsigned CPB   = 16;
   localparam int unsigned DEPTH = 8;
   // Cycles from the edge after which rxd falls to the stop-bit sample edge:
   // 2 synchronizer flops + detect, half a bit, 8 data bits, 1 stop bit.
   localparam int PushOfs = 3 + CPB / 2 + 9 * CPB;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       rxd = 1'b1;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic       frame_err;
   logic       overflow;
   logic [7:0] drop_count;
   logic       busy;

   uart_rx_monitor #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .rxd        (rxd),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .frame_err  (frame_err),
      .overflow   (overflow),
      .drop_count (drop_count),
      .busy       (busy)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [7:0] data;
      bit         ok;
   } ev_t;

   ev_t        sched[$];
   logic [7:0] mq[$];
   logic [7:0] popped[$];
   bit         m_ovf = 1'b0;
   int         m_drop = 0;
   int         fe_cyc = -1;
   int         fe_seen = 0;
   bit         chk_en = 1'b0;
   int         n_checks = 0;
   int         n_pass = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Check the DUT against the model, then advance the model across the next edge.
   task automatic compare_loop();
      ev_t e;
      forever begin
         @(negedge clock);
         if (chk_en) begin
            check("out_valid", out_valid, (mq.size() != 0));
            if (mq.size() != 0) check("out_data", out_data, mq[0]);
            check("frame_err", frame_err, (fe_cyc == cyc));
            check("overflow", overflow, m_ovf);
            check("drop_count", drop_count, m_drop);
            if (frame_err) fe_seen++;
            if (out_valid && out_ready) popped.push_back(out_data);
            if (out_ready && mq.size() != 0) void'(mq.pop_front());
            if (sched.size() != 0 && sched[0].at == cyc + 1) begin
               e = sched.pop_front();
               if (!e.ok) begin
                  fe_cyc = cyc + 1;
               end else if (mq.size() < DEPTH) begin
                  mq.push_back(e.data);
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop != 255) m_drop++;
               end
            end
         end
      end
   endtask

   // One 8N1 frame. When stop == 0 the stop bit is driven low and rxd is left low.
   task automatic send(input logic [7:0] b, input bit stop);
      ev_t e;
      @(posedge clock);
      #1;
      rxd    = 1'b0;
      e.at   = cyc + PushOfs;
      e.data = b;
      e.ok   = stop;
      sched.push_back(e);
      repeat (CPB) @(posedge clock);
      #1;
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (CPB) @(posedge clock);
         #1;
      end
      rxd = stop;
      repeat (CPB) @(posedge clock);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      fork
         compare_loop();
      join_none

      // Reset state
      wait_cycles(3);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_overflow", overflow, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_busy", busy, 0);
      reset  = 1'b1;
      chk_en = 1'b1;
      wait_cycles(4);

      // Single byte with the consumer always ready
      out_ready = 1'b1;
      send(8'hA5, 1'b1);
      wait_cycles(20);
      check("a5_pop_count", popped.size(), 1);
      if (popped.size() == 1) check("a5_byte", popped[0], 8'hA5);
      check("a5_no_frame_err", fe_seen, 0);
      popped.delete();

      // Start-bit glitch shorter than half a bit
      @(posedge clock);
      #1;
      rxd = 1'b0;
      wait_cycles(5);
      rxd = 1'b1;
      check("glitch_busy_during", busy, 1);
      wait_cycles(8);
      check("glitch_busy_after", busy, 0);
      check("glitch_no_frame_err", fe_seen, 0);
      check("glitch_no_push", popped.size(), 0);

      // Low stop bit followed by a long break
      send(8'h3C, 1'b0);
      wait_cycles(100 * CPB);
      check("break_busy", busy, 1);
      rxd = 1'b1;
      wait_cycles(8);
      check("break_busy_after", busy, 0);
      check("break_one_frame_err", fe_seen, 1);
      check("break_no_push", popped.size(), 0);

      // Overfill with the consumer stalled
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(8'(i), 1'b1);
      wait_cycles(20);
      check("ovf_flag", overflow, 1);
      check("ovf_drop_count", drop_count, 2);
      check("ovf_valid", out_valid, 1);
      out_ready = 1'b1;
      wait_cycles(12);
      out_ready = 1'b0;
      check("ovf_pop_count", popped.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < popped.size()) check("ovf_pop_byte", popped[i], i);
      end
      popped.delete();

      // Full FIFO with a pop in the push cycle
      for (int i = 0; i < 8; i++) send(8'h60 + 8'(i), 1'b1);
      wait_cycles(20);
      check("full_pre_drop_count", drop_count, 2);
      fork
         send(8'h55, 1'b1);
         begin
            @(posedge clock);
            repeat (PushOfs - 1) @(posedge clock);
            #1;
            out_ready = 1'b1;
            @(posedge clock);
            #1;
            out_ready = 1'b0;
         end
      join
      wait_cycles(20);
      check("full_pop_drop_count", drop_count, 2);
      out_ready = 1'b1;
      wait_cycles(12);
      out_ready = 1'b0;
      check("full_pop_count", popped.size(), 9);
      for (int i = 0; i < 8; i++) begin
         if (i < popped.size()) check("full_pop_byte", popped[i], 8'h60 + i);
      end
      if (popped.size() == 9) check("full_pop_last", popped[8], 8'h55);
      popped.delete();

      // Reset in the middle of a frame
      fork
         send(8'hFF, 1'b1);
         begin
            wait_cycles(60);
            chk_en = 1'b0;
            reset  = 1'b0;
            sched.delete();
            mq.delete();
            m_ovf  = 1'b0;
            m_drop = 0;
            fe_cyc = -1;
            wait_cycles(3);
            check("midrst_busy", busy, 0);
            check("midrst_overflow", overflow, 0);
            check("midrst_drop_count", drop_count, 0);
            reset = 1'b1;
            wait_cycles(2);
            chk_en = 1'b1;
         end
      join
      wait_cycles(4);
      check("midrst_no_push", out_valid, 0);
      send(8'h12, 1'b1);
      wait_cycles(20);
      check("post_rst_valid", out_valid, 1);
      check("post_rst_data", out_data, 8'h12);
      check("post_rst_overflow", overflow, 0);
      check("post_rst_drop_count", drop_count, 0);
      check("post_rst_frame_err", fe_seen, 1);
      out_ready = 1'b1;
      wait_cycles(4);
      out_ready = 1'b0;
      check("post_rst_pop_count", popped.size(), 1);
      if (popped.size() == 1) check("post_rst_pop_byte", popped[0], 8'h12);
      check("post_rst_empty", out_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
